du_cmd_dispatcher: RTL and testbench

Debug unit command front-end. It sits between the UART FIFOs and the instruction-memory loader. It consumes single-byte host commands from the UART Rx FIFO and then does one of the following: hands the UART link to the loader for a firmware download, starts or stops the CPU, single-steps it, or resets it. It supervises the loader with an inactivity timeout, so a failed download cannot hang the debug unit.

---
 rtl/du_cmd_dispatcher.sv | 163 ++++++++++++++++
 tb/tb_du_cmd_dispatcher.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/du_cmd_dispatcher.sv
// Debug-unit command front-end: decodes host command bytes from the UART Rx FIFO,
// drives CPU run/step/reset, and hands the UART link to the loader under a timeout.
module du_cmd_dispatcher #(
    parameter int NB_UART_DATA = 8,
    parameter int NB_TIMEOUT   = 24
) (
    input  logic                    clk,
    input  logic                    i_rst,
    input  logic                    i_rx_valid,
    input  logic [NB_UART_DATA-1:0] i_rx_data,
    output logic                    o_rx_rd,
    output logic                    o_tx_wr,
    output logic [NB_UART_DATA-1:0] o_tx_wdata,
    output logic                    o_tx_start,
    output logic                    o_ld_start,
    output logic                    o_ld_rx_done,
    output logic                    o_ld_rst,
    input  logic                    i_ld_rd,
    input  logic                    i_ld_wr,
    input  logic                    i_ld_tx_start,
    input  logic [NB_UART_DATA-1:0] i_ld_wdata,
    input  logic                    i_ld_done,
    output logic                    o_cpu_run,
    output logic                    o_cpu_step,
    output logic                    o_cpu_rst,
    input  logic                    i_cpu_halt
);

    localparam logic [NB_UART_DATA-1:0] CMD_LOAD  = NB_UART_DATA'(8'h4C);
    localparam logic [NB_UART_DATA-1:0] CMD_RUN   = NB_UART_DATA'(8'h52);
    localparam logic [NB_UART_DATA-1:0] CMD_STEP  = NB_UART_DATA'(8'h53);
    localparam logic [NB_UART_DATA-1:0] CMD_RESET = NB_UART_DATA'(8'h58);
    localparam logic [NB_UART_DATA-1:0] CMD_HALT  = NB_UART_DATA'(8'h48);
    localparam logic [NB_UART_DATA-1:0] RSP_ACK    = NB_UART_DATA'(8'h05);
    localparam logic [NB_UART_DATA-1:0] RSP_NAK    = NB_UART_DATA'(8'h15);
    localparam logic [NB_UART_DATA-1:0] RSP_HALTED = NB_UART_DATA'(8'h04);

    // The register holds idle cycles already elapsed; the current idle cycle makes it
    // all-ones when the register reads all-ones minus one.
    localparam logic [NB_TIMEOUT-1:0] CNT_LAST = ~NB_TIMEOUT'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LD_START = 2'd1,
        LOAD     = 2'd2,
        RUN      = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [NB_TIMEOUT-1:0]   cnt;
    logic [NB_TIMEOUT-1:0]   cnt_nxt;
    logic                    timeout;

    assign timeout = (state == LOAD) && !i_rx_valid && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        o_rx_rd      = 1'b0;
        o_tx_wr      = 1'b0;
        o_tx_wdata   = '0;
        o_tx_start   = 1'b0;
        o_ld_start   = 1'b0;
        o_ld_rx_done = 1'b0;
        o_ld_rst     = 1'b0;
        o_cpu_run    = 1'b0;
        o_cpu_step   = 1'b0;
        o_cpu_rst    = 1'b0;

        if (!i_rst) begin
            case (state)
                IDLE: begin
                    if (i_rx_valid) begin
                        o_rx_rd = 1'b1;
                        case (i_rx_data)
                            CMD_LOAD: state_nxt = LD_START;
                            CMD_RUN: begin
                                o_tx_wr    = 1'b1;
                                o_tx_start = 1'b1;
                                o_tx_wdata = RSP_ACK;
                                state_nxt  = RUN;
                            end
                            CMD_STEP: begin
                                o_cpu_step = 1'b1;
                                o_tx_wr    = 1'b1;
                                o_tx_start = 1'b1;
                                o_tx_wdata = RSP_ACK;
                            end
                            CMD_RESET: begin
                                o_cpu_rst  = 1'b1;
                                o_tx_wr    = 1'b1;
                                o_tx_start = 1'b1;
                                o_tx_wdata = RSP_ACK;
                            end
                            default: begin
                                o_tx_wr    = 1'b1;
                                o_tx_start = 1'b1;
                                o_tx_wdata = RSP_NAK;
                            end
                        endcase
                    end
                end

                LD_START: begin
                    o_ld_start = 1'b1;
                    cnt_nxt    = '0;
                    state_nxt  = LOAD;
                end

                LOAD: begin
                    o_ld_rx_done = i_rx_valid;
                    o_rx_rd      = i_ld_rd;
                    o_tx_wr      = i_ld_wr;
                    o_tx_start   = i_ld_tx_start;
                    o_tx_wdata   = i_ld_wdata;
                    cnt_nxt      = i_rx_valid ? '0 : cnt + NB_TIMEOUT'(1);
                    if (timeout) begin
                        // Abort the loader and report failure instead of its traffic.
                        o_ld_rst   = 1'b1;
                        o_tx_wr    = 1'b1;
                        o_tx_start = 1'b1;
                        o_tx_wdata = RSP_NAK;
                        cnt_nxt    = '0;
                        state_nxt  = IDLE;
                    end else if (i_ld_done && i_ld_rd) begin
                        state_nxt = IDLE;
                    end
                end

                RUN: begin
                    o_cpu_run = 1'b1;
                    o_rx_rd   = i_rx_valid;
                    // Halt wins over a simultaneous 'H' so only one response is sent.
                    if (i_cpu_halt) begin
                        o_tx_wr    = 1'b1;
                        o_tx_start = 1'b1;
                        o_tx_wdata = RSP_HALTED;
                        state_nxt  = IDLE;
                    end else if (i_rx_valid && (i_rx_data == CMD_HALT)) begin
                        o_tx_wr    = 1'b1;
                        o_tx_start = 1'b1;
                        o_tx_wdata = RSP_ACK;
                        state_nxt  = IDLE;
                    end
                end

                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_du_cmd_dispatcher.sv
// Directed bench for du_cmd_dispatcher: every output is compared as one packed
// vector against hand-computed values at each step.
module tb_du_cmd_dispatcher;

    logic       clk = 1'b0;
    logic       i_rst;
    logic       i_rx_valid;
    logic [7:0] i_rx_data;
    logic       o_rx_rd, o_tx_wr, o_tx_start, o_ld_start, o_ld_rx_done, o_ld_rst;
    logic [7:0] o_tx_wdata;
    logic       i_ld_rd, i_ld_wr, i_ld_tx_start, i_ld_done;
    logic [7:0] i_ld_wdata;
    logic       o_cpu_run, o_cpu_step, o_cpu_rst, i_cpu_halt;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    du_cmd_dispatcher #(.NB_UART_DATA(8), .NB_TIMEOUT(4)) dut (
        .clk(clk), .i_rst(i_rst),
        .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data), .o_rx_rd(o_rx_rd),
        .o_tx_wr(o_tx_wr), .o_tx_wdata(o_tx_wdata), .o_tx_start(o_tx_start),
        .o_ld_start(o_ld_start), .o_ld_rx_done(o_ld_rx_done), .o_ld_rst(o_ld_rst),
        .i_ld_rd(i_ld_rd), .i_ld_wr(i_ld_wr), .i_ld_tx_start(i_ld_tx_start),
        .i_ld_wdata(i_ld_wdata), .i_ld_done(i_ld_done),
        .o_cpu_run(o_cpu_run), .o_cpu_step(o_cpu_step), .o_cpu_rst(o_cpu_rst),
        .i_cpu_halt(i_cpu_halt)
    );

    // {rx_rd, tx_wr, tx_wdata, tx_start, ld_start, ld_rx_done, ld_rst, cpu_run, cpu_step, cpu_rst}
    function automatic logic [16:0] ev(input logic rd, input logic wr, input logic [7:0] d,
                                       input logic st, input logic lds, input logic ldrx,
                                       input logic ldr, input logic run, input logic stp,
                                       input logic crst);
        return {rd, wr, d, st, lds, ldrx, ldr, run, stp, crst};
    endfunction

    task automatic chk(input string tag, input logic [16:0] exp);
        logic [16:0] got;
        #1;
        got = {o_rx_rd, o_tx_wr, o_tx_wdata, o_tx_start, o_ld_start, o_ld_rx_done,
               o_ld_rst, o_cpu_run, o_cpu_step, o_cpu_rst};
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%05h exp=%05h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        i_rx_valid = 0; i_rx_data = 8'h00; i_ld_rd = 0; i_ld_wr = 0;
        i_ld_tx_start = 0; i_ld_wdata = 8'h00; i_ld_done = 0; i_cpu_halt = 0;
    endtask

    task automatic byte_in(input logic [7:0] b);
        quiet();
        i_rx_valid = 1; i_rx_data = b;
    endtask

    localparam logic [16:0] ZERO = 17'h0;

    initial begin
        i_rst = 1;
        quiet();
        tick(); tick();
        i_rst = 0;
        chk("reset", ZERO);

        // Step then unknown byte
        byte_in(8'h53); chk("step", ev(1,1,8'h05,1,0,0,0,0,1,0)); tick();
        byte_in(8'h7A); chk("nak", ev(1,1,8'h15,1,0,0,0,0,0,0)); tick();
        byte_in(8'h58); chk("cpu_rst", ev(1,1,8'h05,1,0,0,0,0,0,1)); tick();
        byte_in(8'h48); chk("h_idle", ev(1,1,8'h15,1,0,0,0,0,0,0)); tick();

        // Load with passthrough and EOT
        byte_in(8'h4C); chk("l_pop", ev(1,0,8'h00,0,0,0,0,0,0,0)); tick();
        quiet(); chk("ld_start", ev(0,0,8'h00,0,1,0,0,0,0,0)); tick();
        byte_in(8'hAA); i_ld_rd = 1; i_ld_wr = 1; i_ld_wdata = 8'h3C;
        chk("pass1", ev(1,1,8'h3C,0,0,1,0,0,0,0)); tick();
        quiet(); i_ld_tx_start = 1; i_ld_wdata = 8'hC3;
        chk("pass2", ev(0,0,8'hC3,1,0,0,0,0,0,0)); tick();
        byte_in(8'h04); i_ld_rd = 1; i_ld_done = 1; i_ld_wr = 1; i_ld_tx_start = 1;
        i_ld_wdata = 8'h05;
        chk("eot", ev(1,1,8'h05,1,0,1,0,0,0,0)); tick();
        byte_in(8'h53); chk("step_after_ld", ev(1,1,8'h05,1,0,0,0,0,1,0)); tick();

        // Timeout with no bytes: fires 15 cycles after LD_START
        byte_in(8'h4C); chk("l_pop2", ev(1,0,8'h00,0,0,0,0,0,0,0)); tick();
        quiet(); tick();
        for (int i = 1; i <= 14; i++) begin
            chk("to_wait", ZERO); tick();
        end
        chk("timeout", ev(0,1,8'h15,1,0,0,1,0,0,0)); tick();
        i_ld_wr = 1; i_ld_rd = 1; i_ld_tx_start = 1; i_ld_wdata = 8'hEE;
        chk("idle_ign_ld", ZERO); tick();

        // Timeout restarted by a byte at LOAD cycle 14
        byte_in(8'h4C); tick();
        quiet(); tick();
        for (int i = 1; i <= 13; i++) begin
            chk("to2_wait", ZERO); tick();
        end
        byte_in(8'h11); chk("to2_byte", ev(0,0,8'h00,0,0,1,0,0,0,0)); tick();
        quiet();
        for (int i = 1; i <= 14; i++) begin
            chk("to2_rewait", ZERO); tick();
        end
        chk("timeout2", ev(0,1,8'h15,1,0,0,1,0,0,0)); tick();
        chk("idle_after_to", ZERO); tick();

        // Run then halt after 10 cycles
        byte_in(8'h52); chk("run_ack", ev(1,1,8'h05,1,0,0,0,0,0,0)); tick();
        quiet();
        for (int i = 0; i < 10; i++) begin
            chk("running", ev(0,0,8'h00,0,0,0,0,1,0,0)); tick();
        end
        i_cpu_halt = 1; chk("halted", ev(0,1,8'h04,1,0,0,0,1,0,0)); tick();
        quiet(); chk("run_drop", ZERO); tick();

        // Run: discard, then 'H' with halt together
        byte_in(8'h52); tick();
        byte_in(8'h41); chk("discard", ev(1,0,8'h00,0,0,0,0,1,0,0)); tick();
        byte_in(8'h48); i_cpu_halt = 1;
        chk("h_and_halt", ev(1,1,8'h04,1,0,0,0,1,0,0)); tick();
        quiet(); chk("idle_after_hh", ZERO); tick();
        byte_in(8'h52); tick();
        byte_in(8'h48); chk("h_ack", ev(1,1,8'h05,1,0,0,0,1,0,0)); tick();
        quiet(); chk("idle_after_h", ZERO); tick();

        // Reset mid-LOAD and mid-RUN
        byte_in(8'h4C); tick();
        quiet(); tick();
        i_rst = 1; tick();
        i_rst = 0; i_ld_rd = 1; i_ld_wr = 1; i_ld_tx_start = 1; i_ld_wdata = 8'hFF;
        i_ld_done = 1;
        chk("rst_mid_load", ZERO); tick();
        byte_in(8'h52); tick();
        quiet(); chk("run_pre_rst", ev(0,0,8'h00,0,0,0,0,1,0,0));
        i_rst = 1; tick();
        i_rst = 0; chk("rst_mid_run", ZERO); tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
